div_unit: RTL and testbench

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. Sits directly downstream of the register file read ports: it takes the two operands read from the register file and the destination register index. After a fixed number of cycles it produces a result and a one-cycle write request for the register file write port (write-enable, address, data). The control path uses `busy` to stall while a divide is in progress.

---
 rtl/rv32m_pkg.sv | 19 +
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 120 ++++++++++++
 tb/tb_div_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: op encodings, divider FSM states, default width.
package rv32m_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, try to subtract divisor.
module div_step
  import rv32m_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          borrow;

  // Partial remainder is always below the divisor, so XLEN+1 bits hold both
  // the shifted value and the trial difference; the MSB is the borrow.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {1'b0, divisor};
    borrow  = trial[XLEN];
    rem_nxt = borrow ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) with register-file write request.
module div_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            wb_we,
  output logic [4:0]      wb_addr
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            sign_q, sign_r, is_rem;

  logic            accept, signed_op, a_neg, b_neg, div0, ovf, fast;
  logic [XLEN-1:0] a_abs, b_abs, fast_res;
  logic [XLEN-1:0] step_rem, step_quo, calc_res;

  assign busy  = (state == S_CALC);
  assign done  = (state == S_DONE);
  assign wb_we = done && (wb_addr != 5'd0);

  // Operand conditioning and special-case detection at accept time.
  always_comb begin
    accept    = start && (state == S_IDLE || state == S_DONE);
    signed_op = ~op[0];
    a_neg     = signed_op & A[XLEN-1];
    b_neg     = signed_op & B[XLEN-1];
    a_abs     = a_neg ? -A : A;
    b_abs     = b_neg ? -B : B;
    div0      = (B == '0);
    ovf       = signed_op && (A == MIN_NEG) && (B == '1);
    fast      = div0 || ovf;
    // Divide-by-zero wins: REM returns A untouched, DIV returns all ones.
    if (div0)
      fast_res = op[1] ? A : '1;
    else
      fast_res = op[1] ? '0 : MIN_NEG;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  // Final-step result with sign correction, captured on the way into DONE.
  always_comb begin
    if (is_rem)
      calc_res = sign_r ? -step_rem : step_rem;
    else
      calc_res = sign_q ? -step_quo : step_quo;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = fast ? S_DONE : S_CALC;
      S_CALC:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = fast ? S_DONE : S_CALC;
               else       state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath: latch operands on accept, iterate in CALC, register the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      is_rem  <= 1'b0;
      result  <= '0;
      wb_addr <= 5'd0;
    end else if (accept) begin
      wb_addr <= rd;
      is_rem  <= op[1];
      sign_q  <= a_neg ^ b_neg;
      sign_r  <= a_neg;
      rem_q   <= '0;
      quo_q   <= a_abs;
      dvs_q   <= b_abs;
      cnt     <= CW'(ITER - 1);
      if (fast) result <= fast_res;
    end else if (state == S_CALC) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      cnt   <= cnt - 1'b1;
      if (cnt == '0) result <= calc_res;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expectations, monitor checks on done.
module tb_div_unit;
  import rv32m_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, wb_we;
  logic [31:0] result;
  logic [4:0]  wb_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [4:0]  addr;
    logic        we;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  div_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B), .rd(rd),
    .busy(busy), .done(done), .result(result), .wb_we(wb_we), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done/wb_we pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (done || wb_we)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: done=%0b wb_we=%0b result=%h cyc=%0d", done, wb_we, result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (!done || result !== e.res || wb_addr !== e.addr || wb_we !== e.we || cyc != e.cyc) begin
          bad++;
          $display("FAIL %s: got done=%0b result=%h addr=%0d we=%0b cyc=%0d, want result=%h addr=%0d we=%0b cyc=%0d",
                   e.tag, done, result, wb_addr, wb_we, cyc, e.res, e.addr, e.we, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Drive one request (call right after a negedge); lat counts cycles from accept to done.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [31:0] res, input int lat, input string tag);
    exp_t e;
    start = 1'b1; op = o; A = a; B = b; rd = r;
    @(posedge clk);
    #1;
    e.tag = tag; e.res = res; e.addr = r; e.we = (r != 5'd0); e.cyc = cyc + lat;
    sb.push_back(e);
    start = 1'b0;
    A = $urandom; B = $urandom; rd = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: %0d expected results never appeared", sb.size());
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int nb;
    int n0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(busy),    32'd0);
    chk("rst_done",   32'(done),    32'd0);
    chk("rst_wb_we",  32'(wb_we),   32'd0);
    chk("rst_result", result,       32'd0);
    chk("rst_addr",   32'(wb_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // DIVU 100/7: busy for 32 cycles, done on the 33rd.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 32, "divu_100_7");
    nb = 0;
    repeat (33) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("busy_cycles", 32'(nb), 32'd32);
    drain();

    issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 32, "rem_m7_2");   drain();
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 32, "div_m7_2");   drain();
    issue(OP_DIV,  32'd1234, 32'd0, 5'd6, 32'hFFFF_FFFF, 0, "div_by0");          drain();
    issue(OP_REMU, 32'd1234, 32'd0, 5'd7, 32'd1234, 0, "remu_by0");              drain();
    issue(OP_REM,  32'hFFFF_FFFB, 32'd0, 5'd8, 32'hFFFF_FFFB, 0, "rem_neg_by0"); drain();
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 0, "div_ovf"); drain();
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 0, "rem_ovf");    drain();
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 32, "divu_nofast"); drain();
    issue(OP_DIV,  32'h8000_0000, 32'd2, 5'd12, 32'hC000_0000, 32, "div_min_2"); drain();
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd13, 32'hFFFF_FFFF, 32, "divu_max_1"); drain();
    issue(OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd14, 32'h0000_000F, 32, "remu_max_16"); drain();
    issue(OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd15, 32'd1, 32, "rem_7_m2");          drain();

    // Start during CALC must be ignored: exactly one done follows.
    issue(OP_DIVU, 32'd1000, 32'd10, 5'd16, 32'd100, 32, "divu_ignore_start");
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_DIV; A = 32'd1; B = 32'd0; rd = 5'd17;
    @(posedge clk);
    #1 start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Reset mid-CALC aborts with no write request.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 32, "divu_aborted");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("abort_busy",   32'(busy),    32'd0);
    chk("abort_done",   32'(done),    32'd0);
    chk("abort_result", result,       32'd0);
    chk("abort_addr",   32'(wb_addr), 32'd0);
    repeat (40) @(negedge clk);

    // Back-to-back: new start held during DONE, rd=0 so no write enable.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 32, "b2b_first");
    n0 = cyc;
    repeat (33) @(negedge clk);
    chk("b2b_align", 32'(cyc - n0), 32'd32);
    issue(OP_DIVU, 32'd9, 32'd3, 5'd0, 32'd3, 32, "b2b_second");
    chk("b2b_busy_no_gap", 32'(busy), 32'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
